// File: rtl/mdu_seq_if.sv
// EX-stage to multiply/divide sequencer bus: the issue request, MTHI/MTLO writes,
// and the status and HI/LO result lines.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO. It does one shift-add or
// shift-subtract step per cycle, and every op has a fixed latency of WIDTH+2 cycles.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mdu_seq_if.slave     bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_save_q, a_save_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes: the signed ops take the absolute value, the unsigned ops pass the raw value.
  logic             op_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign op_signed = ~bus.op[0];
  assign mag_a = (op_signed && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
  assign mag_b = (op_signed && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

  // Multiply step: add the multiplicand to the upper half, keep the carry, then shift right.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step. The shifted remainder can be WIDTH+1 bits, so the compare is
  // done at that width.
  logic             div_commit;
  logic [WIDTH-1:0] div_sub;
  logic [W2-1:0]    div_step;
  assign div_commit = acc_q[W2-1:WIDTH-1] >= {1'b0, opnd_q};
  assign div_sub    = acc_q[W2-2:WIDTH-1] - opnd_q;
  assign div_step   = {(div_commit ? div_sub : acc_q[W2-2:WIDTH-1]),
                       acc_q[WIDTH-2:0], div_commit};

  // Sign correction applied in FIX.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? W2'(-acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? WIDTH'(-acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_save_d  = a_save_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d   = CALC;
          busy_d    = 1'b1;
          cnt_d     = CW'(WIDTH);
          is_div_d  = bus.op[1];
          neg_res_d = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = op_signed & bus.a[WIDTH-1];
          dbz_d     = bus.op[1] & (bus.b == '0);
          a_save_d  = bus.a;
          opnd_d    = bus.op[1] ? mag_b : mag_a;
          acc_d     = {WIDTH'(0), (bus.op[1] ? mag_a : mag_b)};
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
          acc_d = is_div_q ? div_step : mul_step;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
          hi_d = a_save_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_save_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_save_q  <= a_save_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: arithmetic results, divide corner cases, latency,
// handshake rules and mid-operation reset.
module tb_mdu_seq;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  mdu_seq_if #(.WIDTH(32)) bus();
  mdu_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count the edges after the start edge until done is seen (0 = timed out).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic busy1);
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy1 = bus.busy;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got=%h exp=0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got=%h exp=0", bus.lo); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int lat; logic b1;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, b1);
    total++; if (b1 !== 1'b1) $display("FAIL multu_busy_rise got=%b exp=1", b1); else passed++;
    total++; if (lat !== 34) $display("FAIL multu_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL multu_busy_at_done got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h00000001) $display("FAIL multu_lo got=%h exp=00000001", bus.lo); else passed++;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL multu_done_one_cycle got=%b exp=0", bus.done); else passed++;
  endtask

  task automatic test_mult();
    int lat; logic b1;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, b1);
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFEB) $display("FAIL mult_neg_lo got=%h exp=ffffffeb", bus.lo); else passed++;
    tick();
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, b1);
    total++; if (bus.hi !== 32'h40000000) $display("FAIL mult_min_hi got=%h exp=40000000", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL mult_min_lo got=%h exp=0", bus.lo); else passed++;
    tick();
  endtask

  task automatic test_div();
    int lat; logic b1;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, b1);
    total++; if (bus.lo !== 32'd14) $display("FAIL divu_lo got=%h exp=0000000e", bus.lo); else passed++;
    total++; if (bus.hi !== 32'd2) $display("FAIL divu_hi got=%h exp=00000002", bus.hi); else passed++;
    tick();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, b1);
    total++; if (bus.lo !== 32'hFFFFFFFD) $display("FAIL div_negnum_lo got=%h exp=fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFF) $display("FAIL div_negnum_hi got=%h exp=ffffffff", bus.hi); else passed++;
    tick();
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, b1);
    total++; if (bus.lo !== 32'hFFFFFFFD) $display("FAIL div_negden_lo got=%h exp=fffffffd", bus.lo); else passed++;
    total++; if (bus.hi !== 32'd1) $display("FAIL div_negden_hi got=%h exp=00000001", bus.hi); else passed++;
    tick();
  endtask

  task automatic test_div_corner();
    int lat; logic b1;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, b1);
    total++; if (bus.lo !== 32'h80000000) $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL div_ovf_hi got=%h exp=0", bus.hi); else passed++;
    tick();
    run_op(OP_DIVU, 32'd5, 32'd0, lat, b1);
    total++; if (lat !== 34) $display("FAIL divu_zero_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.hi !== 32'd5) $display("FAIL divu_zero_hi got=%h exp=00000005", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFF) $display("FAIL divu_zero_lo got=%h exp=ffffffff", bus.lo); else passed++;
    tick();
    run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, lat, b1);
    total++; if (lat !== 34) $display("FAIL div_zero_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.hi !== 32'hFFFFFFFB) $display("FAIL div_zero_hi got=%h exp=fffffffb", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFF) $display("FAIL div_zero_lo got=%h exp=ffffffff", bus.lo); else passed++;
    tick();
  endtask

  task automatic test_hi_we_idle();
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.hi_we = 1'b0;
    total++; if (bus.hi !== 32'h12345678) $display("FAIL mthi_hi got=%h exp=12345678", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hFFFFFFFF) $display("FAIL mthi_lo_kept got=%h exp=ffffffff", bus.lo); else passed++;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    total++; if (bus.hi !== 32'hCAFEF00D) $display("FAIL mthilo_hi got=%h exp=cafef00d", bus.hi); else passed++;
    total++; if (bus.lo !== 32'hCAFEF00D) $display("FAIL mthilo_lo got=%h exp=cafef00d", bus.lo); else passed++;
  endtask

  task automatic test_hi_we_busy();
    int lat;
    bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.hi_we = 1'b0;
    total++; if (bus.hi !== 32'hCAFEF00D) $display("FAIL busy_mthi_dropped got=%h exp=cafef00d", bus.hi); else passed++;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin lat = i + 3; break; end
    end
    total++; if (lat !== 34) $display("FAIL busy_mthi_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL busy_mthi_res_hi got=%h exp=0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'd30) $display("FAIL busy_mthi_res_lo got=%h exp=0000001e", bus.lo); else passed++;
    tick();
  endtask

  task automatic test_start_lo_we();
    int lat;
    bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    bus.lo_we = 1'b1; bus.wdata = 32'h12345678;
    tick();
    bus.start = 1'b0; bus.lo_we = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL start_mtlo_busy got=%b exp=1", bus.busy); else passed++;
    total++; if (bus.lo !== 32'd30) $display("FAIL start_mtlo_dropped got=%h exp=0000001e", bus.lo); else passed++;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin lat = i; break; end
    end
    total++; if (lat !== 34) $display("FAIL start_mtlo_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.lo !== 32'd6) $display("FAIL start_mtlo_res_lo got=%h exp=00000006", bus.lo); else passed++;
    tick();
  endtask

  task automatic test_second_start();
    int lat;
    bus.op = OP_MULTU; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.op = OP_MULTU; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin lat = i + 5; break; end
    end
    total++; if (lat !== 34) $display("FAIL second_start_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.lo !== 32'd42) $display("FAIL second_start_lo got=%h exp=0000002a", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL second_start_hi got=%h exp=0", bus.hi); else passed++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL second_start_no_queue got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; logic b1;
    run_op(OP_MULTU, 32'd3, 32'd5, lat, b1);
    total++; if (bus.lo !== 32'd15) $display("FAIL b2b_first_lo got=%h exp=0000000f", bus.lo); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL b2b_gap_busy got=%b exp=0", bus.busy); else passed++;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, b1);
    total++; if (b1 !== 1'b1) $display("FAIL b2b_second_busy got=%b exp=1", b1); else passed++;
    total++; if (lat !== 34) $display("FAIL b2b_second_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.lo !== 32'd14) $display("FAIL b2b_second_lo got=%h exp=0000000e", bus.lo); else passed++;
    total++; if (bus.hi !== 32'd2) $display("FAIL b2b_second_hi got=%h exp=00000002", bus.hi); else passed++;
    tick();
  endtask

  task automatic test_reset_midop();
    int lat; int ndone; logic b1;
    bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL midreset_done got=%b exp=0", bus.done); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL midreset_hi got=%h exp=0", bus.hi); else passed++;
    total++; if (bus.lo !== 32'h0) $display("FAIL midreset_lo got=%h exp=0", bus.lo); else passed++;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL midreset_stray_done got=%0d exp=0", ndone); else passed++;
    run_op(OP_MULTU, 32'd3, 32'd4, lat, b1);
    total++; if (lat !== 34) $display("FAIL midreset_fresh_latency got=%0d exp=34", lat); else passed++;
    total++; if (bus.lo !== 32'd12) $display("FAIL midreset_fresh_lo got=%h exp=0000000c", bus.lo); else passed++;
    total++; if (bus.hi !== 32'h0) $display("FAIL midreset_fresh_hi got=%h exp=0", bus.hi); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_hi_we_idle();
    test_hi_we_busy();
    test_start_lo_we();
    test_second_start();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS pipeline; implements MULT, MULTU, DIV, DIVU and owns the HI/LO registers.
- The EX stage issues the operation with a one-cycle start pulse.
- The hazard unit stalls on busy for any later MFHI/MFLO/MTHI/MTLO/mul/div.
- Iterates one shift-add / shift-subtract step per cycle. This keeps the wide multiplier and divider out of the single-cycle ALU path.

Parameters:
- WIDTH, 32: operand width. The iteration counter is clog2(WIDTH)+1 bits. Only 32 is verified.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, any state including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
  - An in-flight operation is abandoned with no partial HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge T latches op, the operand magnitudes (abs value for signed ops, raw for unsigned), the result sign bits and a divide-by-zero flag (b==0, div ops).
  - Counter is loaded with WIDTH; next state CALC; busy=1 from T+1.
- CALC, one step per cycle for WIDTH cycles, counter decrements, exits to FIX when the counter reaches 0:
  - Multiply: 2*WIDTH-bit product register. LSB of multiplier=1 adds the multiplicand to the upper half with carry; the register then shifts right 1.
  - Divide: restoring algorithm. The remainder:quotient pair shifts left 1. The trial subtract of the divisor commits if non-negative and sets quotient bit 0.
- FIX, one cycle:
  - Apply sign correction (two's-complement negate) and write HI/LO; next state IDLE.
  - Signed multiply: negate the 64-bit product when the operand signs differ. HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder. Quotient truncates toward zero and is negated when signs differ; remainder takes the dividend's sign.
  - Divide by zero (DIV or DIVU): HI=a, LO=32'hFFFFFFFF, overriding the computed result.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no trap and no flag. This falls out of the 32-bit truncation.
- Completion timing: hi/lo update and done=1 at edge T+WIDTH+2 (34 for WIDTH=32); busy=0 on the same edge. done lasts exactly one cycle.
- Latency is fixed at WIDTH+2 cycles for every op, including divide by zero. There is no early termination.
- New start accepted the cycle done is high (state is IDLE): back-to-back issue gives busy=0 for exactly that one cycle.
- start while busy: ignored, with no queuing. The pipeline must stall on busy.
- hi_we/lo_we:
  - Apply at the next edge only when busy=0 and start=0.
  - Dropped while busy, and dropped if asserted with start in the same cycle (start wins).
  - hi_we and lo_we together are legal and write both from wdata.
- hi/lo are held stable throughout CALC/FIX; the old values stay readable until the completion edge.
- op, a and b are ignored after the start cycle.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy rises next edge and done is seen 34 edges after start.
  - Requires HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0.
- Divide results:
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
- Divide corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU 5/0 and DIV -5/0 -> HI=a, LO=0xFFFFFFFF, both after 34 cycles.
- Handshake:
  - A second start at cycle 5 of a MULTU is ignored; the result is that of the first op.
  - hi_we with wdata=0x12345678 while busy is dropped.
  - start plus lo_we in IDLE: the op runs and the LO write is dropped.
  - hi_we alone in IDLE -> hi=0x12345678 next edge.
- Reset at cycle 10 of a DIV -> next edge busy=0, done=0, hi=lo=0.
  - No done pulse follows.
  - A fresh MULTU 3*4 then completes normally with LO=12, HI=0.
